dmemory_ctrl: RTL

//   Parametrised successor to the single-cycle 32-bit data memory. Byte-addressed

---
 rtl/dmem_pkg.sv | 64 ++++++
 rtl/dmem_bank.sv | 37 +++
 rtl/dmemory_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types, size/state encodings and lane helpers for the data-memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       uns;
    } req_ctl_t;

    // Byte-lane write enables for a store of the given size at byte offset off.
    function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] we;
        we = 4'b0000;
        case (size)
            SZ_BYTE: we = 4'b0001 << off;
            SZ_HALF: we = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    // Replicate right-justified store data onto every lane it may land on.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Shift the addressed byte/half down to bit 0 and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Four byte-lane synchronous RAMs sharing one word index, with per-lane write enable.
module dmem_bank #(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned IDX_W       = 14,
    parameter string       INIT_FILE   = ""
) (
    input  logic             clock,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Simulation zero image; contents are never reset.
    initial begin
        if (INIT_FILE == "") begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int l = 0; l < 4; l++) begin
            if (we[l]) begin
                mem[idx][l] <= wdata[8*l +: 8];
            end
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmemory_ctrl.sv
// Byte-addressed data-memory controller: valid/ready request port, programmable
// wait states, sub-word stores, sign/zero-extended loads and access-error flagging.
module dmemory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned WAIT_STATES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt_q, cnt_next;
    req_ctl_t          ctl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              in_idle;
    logic              cur_write, cur_uns, cur_err;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [WIDX_W-1:0] cur_widx;
    logic              commit;
    logic [3:0]        bank_we;
    logic              bank_re;
    logic [31:0]       bank_rdata;

    // In IDLE the live request drives the datapath (zero-wait commit); afterwards the captured copy does.
    always_comb begin
        in_idle   = (state == ST_IDLE);
        cur_write = in_idle ? req_write    : ctl_q.write;
        cur_size  = in_idle ? req_size     : ctl_q.size;
        cur_uns   = in_idle ? req_unsigned : ctl_q.uns;
        cur_addr  = in_idle ? req_addr     : addr_q;
        cur_wdata = in_idle ? req_wdata    : wdata_q;
        cur_widx  = cur_addr[ADDR_W-1:2];
        cur_err   = (cur_size == SZ_ILL)
                 || ((cur_size == SZ_HALF) && cur_addr[0])
                 || ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00))
                 || (cur_widx >= DEPTH_LIM);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (cur_err) begin
                        state_next = ST_RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_BUSY;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // RAM access happens only on the edge that enters RESP, so an abandoned request never writes.
    always_comb begin
        commit  = (state_next == ST_RESP) && (state != ST_RESP) && !cur_err;
        bank_we = (commit && cur_write) ? lane_we(cur_size, cur_addr[1:0]) : 4'b0000;
        bank_re = commit && !cur_write;
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_bank (
        .clock (clock),
        .we    (bank_we),
        .re    (bank_re),
        .idx   (IDX_W'(cur_widx)),
        .wdata (lane_wdata(cur_size, cur_wdata)),
        .rdata (bank_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt_q     <= '0;
            ctl_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt_q     <= cnt_next;
            if (in_idle && req_valid) begin
                ctl_q   <= '{write: req_write, size: req_size, uns: req_unsigned};
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            req_ready <= (state_next == ST_IDLE);
            rsp_valid <= (state_next == ST_RESP);
            rsp_err   <= (state_next == ST_RESP) && cur_err;
        end
    end

    // Load data comes straight from the RAM output register captured on RESP entry.
    always_comb begin
        rsp_rdata = '0;
        if (rsp_valid && !rsp_err && !ctl_q.write) begin
            rsp_rdata = load_extend(bank_rdata, ctl_q.size, ctl_q.uns, addr_q[1:0]);
        end
    end

endmodule
